wmem_hidden_fetch: RTL and testbench

Read-side sequencer for the hidden-layer weight memory. On a start command for one layer it walks every (neuron, input) weight of that layer in row-major order and drives the memory read address. It absorbs the memory's 1-cycle registered read latency and presents the weights to the MAC datapath as a valid/ready stream with neuron/input tags and row markers. It sits between the layer controller and the MAC array; host writes to the memory bypass this block.

---
 rtl/wmem_hidden_fetch.sv | 203 ++++++++++++++++++++
 tb/tb_wmem_hidden_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wmem_hidden_fetch.sv
`default_nettype none
// ============================================================================
// Module     : wmem_hidden_fetch
// Description: Walks one hidden layer's weights row-major, hides the 1-cycle
//              memory read latency and streams weights out as valid/ready.
//              Define WMEM_FETCH_PERF_EN to add stall_cnt_o / fetch_cyc_o.
// Revision   : 1.0 - initial release
// ============================================================================
module wmem_hidden_fetch #(
   parameter  int DATA_W   = 16,
   parameter  int N_IN     = 128,
   parameter  int N_HIDDEN = 64,
   parameter  int N_LAYERS = 3,
   localparam int AW = $clog2((N_LAYERS*N_HIDDEN*N_IN > 2) ? N_LAYERS*N_HIDDEN*N_IN : 2),
   localparam int LW = $clog2((N_LAYERS > 2) ? N_LAYERS : 2),
   localparam int HW = $clog2((N_HIDDEN > 2) ? N_HIDDEN : 2),
   localparam int IW = $clog2((N_IN > 2) ? N_IN : 2)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [LW-1:0]            layer_i,
   input  logic                     abort_i,
   output logic [AW-1:0]            raddr_o,
   input  logic signed [DATA_W-1:0] rdata_i,
   output logic                     w_valid_o,
   input  logic                     w_ready_i,
   output logic signed [DATA_W-1:0] w_data_o,
   output logic [HW-1:0]            w_h_o,
   output logic [IW-1:0]            w_i_o,
   output logic                     w_first_o,
   output logic                     w_last_o,
   output logic                     busy_o,
   output logic                     done_o,
`ifdef WMEM_FETCH_PERF_EN
   output logic [31:0]              stall_cnt_o,
   output logic [31:0]              fetch_cyc_o,
`endif
   output logic                     err_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [LW:0]   LAYER_LIM  = (LW+1)'(N_LAYERS);
   localparam logic [HW-1:0] H_LAST     = HW'(N_HIDDEN-1);
   localparam logic [IW-1:0] I_LAST     = IW'(N_IN-1);
   localparam logic [AW-1:0] LAYER_SIZE = AW'(N_HIDDEN*N_IN);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] addr_q;
   logic [HW-1:0] h_q;
   logic [IW-1:0] i_q;
   logic          infl_q;
   logic [HW-1:0] infl_h_q;
   logic [IW-1:0] infl_i_q;
   logic          err_q;

   logic signed [DATA_W-1:0] buf_data_q [2];
   logic [HW-1:0]            buf_h_q    [2];
   logic [IW-1:0]            buf_i_q    [2];
   logic                     rd_ptr_q, wr_ptr_q;
   logic [1:0]               cnt_q, cnt_d;

   logic          start_ok, start_bad, flush, issue, last_issue, pop, push;
   logic [2:0]    occ;
   logic [AW-1:0] base;

   always_comb begin
      start_ok   = (state_q == S_IDLE) && start_i && ({1'b0, layer_i} < LAYER_LIM);
      start_bad  = (state_q == S_IDLE) && start_i && ({1'b0, layer_i} >= LAYER_LIM);
      flush      = abort_i && (state_q != S_IDLE);
      base       = AW'(layer_i) * LAYER_SIZE;
      pop        = (cnt_q != 2'd0) && w_ready_i;
      push       = infl_q;
      cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
      // Occupancy after this edge if nothing is issued; keeps buffer+inflight <= 2.
      occ        = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
      issue      = (state_q == S_RUN) && !abort_i && (occ < 3'd2);
      last_issue = (h_q == H_LAST) && (i_q == I_LAST);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_ok) state_d = S_RUN;
         S_RUN:   if (issue && last_issue) state_d = S_DRAIN;
         S_DRAIN: if (!infl_q && (cnt_d == 2'd0)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_comb begin
      busy_o = (state_q != S_IDLE);
      done_o = (state_q == S_DONE);
   end

   // Issue counters; the address simply steps by one because rows are contiguous.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= '0;
         h_q    <= '0;
         i_q    <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= start_bad;
         if (start_ok) begin
            addr_q <= base;
            h_q    <= '0;
            i_q    <= '0;
         end else if (issue && !last_issue) begin
            addr_q <= addr_q + AW'(1);
            if (i_q == I_LAST) begin
               i_q <= '0;
               h_q <= h_q + HW'(1);
            end else begin
               i_q <= i_q + IW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         infl_q   <= 1'b0;
         infl_h_q <= '0;
         infl_i_q <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         for (int e = 0; e < 2; e++) begin
            buf_data_q[e] <= '0;
            buf_h_q[e]    <= '0;
            buf_i_q[e]    <= '0;
         end
      end else if (flush) begin
         infl_q   <= 1'b0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         infl_q <= issue;
         if (issue) begin
            infl_h_q <= h_q;
            infl_i_q <= i_q;
         end
         if (push) begin
            buf_data_q[wr_ptr_q] <= rdata_i;
            buf_h_q[wr_ptr_q]    <= infl_h_q;
            buf_i_q[wr_ptr_q]    <= infl_i_q;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      raddr_o   = addr_q;
      w_valid_o = (cnt_q != 2'd0);
      w_data_o  = buf_data_q[rd_ptr_q];
      w_h_o     = buf_h_q[rd_ptr_q];
      w_i_o     = buf_i_q[rd_ptr_q];
      w_first_o = w_valid_o && (buf_i_q[rd_ptr_q] == '0);
      w_last_o  = w_valid_o && (buf_i_q[rd_ptr_q] == I_LAST);
      err_o     = err_q;
   end

`ifdef WMEM_FETCH_PERF_EN
   logic [31:0] stall_q, fcyc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
         fcyc_q  <= '0;
      end else if (start_ok) begin
         stall_q <= '0;
         fcyc_q  <= '0;
      end else begin
         if (w_valid_o && !w_ready_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (((state_q == S_RUN) || (state_q == S_DRAIN)) && (fcyc_q != '1))
            fcyc_q <= fcyc_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_q;
   assign fetch_cyc_o = fcyc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wmem_hidden_fetch.sv
`default_nettype none
// ============================================================================
// Module     : tb_wmem_hidden_fetch
// Description: Self-checking bench for wmem_hidden_fetch (N_IN=4, N_HIDDEN=2).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_wmem_hidden_fetch;

   localparam int N_IN = 4;
   localparam int N_HIDDEN = 2;
   localparam int N_LAYERS = 3;
   localparam int NW = N_IN * N_HIDDEN;
   localparam int AW = 5;
   localparam int LW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [LW-1:0]     layer = '0;
   logic              abort = 1'b0;
   logic [AW-1:0]     raddr;
   logic signed [15:0] rdata = '0;
   logic              w_valid;
   logic              w_ready = 1'b0;
   logic signed [15:0] w_data;
   logic [0:0]        w_h;
   logic [1:0]        w_i;
   logic              w_first, w_last, busy, done, err;
`ifdef WMEM_FETCH_PERF_EN
   logic [31:0]       stall_cnt, fetch_cyc;
`endif

   int checks = 0;
   int failures = 0;

   wmem_hidden_fetch #(
      .DATA_W(16), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .N_LAYERS(N_LAYERS)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .layer_i(layer), .abort_i(abort),
      .raddr_o(raddr), .rdata_i(rdata), .w_valid_o(w_valid), .w_ready_i(w_ready),
      .w_data_o(w_data), .w_h_o(w_h), .w_i_o(w_i), .w_first_o(w_first),
      .w_last_o(w_last), .busy_o(busy), .done_o(done),
`ifdef WMEM_FETCH_PERF_EN
      .stall_cnt_o(stall_cnt), .fetch_cyc_o(fetch_cyc),
`endif
      .err_o(err)
   );

   initial forever #5 clk = ~clk;

   // Registered-read memory with contents mem[a] = a.
   always @(posedge clk) rdata <= 16'(raddr);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [20:0] exp_word(input int lay, input int k);
      logic [15:0] d;
      logic [0:0]  h;
      logic [1:0]  i;
      d = 16'(lay * NW + k);
      h = 1'(k / N_IN);
      i = 2'(k % N_IN);
      return {d, h, i, (k % N_IN) == 0, (k % N_IN) == N_IN - 1};
   endfunction

   function automatic logic [31:0] all_outs();
      return {raddr, w_valid, w_data, w_h, w_i, w_first, w_last, busy, done, err};
   endfunction

   // mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random, 3 ready low for 5 cycles
   task automatic run_layer(input int lay, input int mode, input bit poke,
                            input int abort_at, input int reset_at);
      int  k = 0;
      int  cyc;
      int  first_v = -1;
      int  stalls = 0;
      bit  r;
      bit  saw_done = 1'b0;
      int  exp_a;
      layer = LW'(lay);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (k < NW && cyc < 400) begin
         if (done) saw_done = 1'b1;
         chk("busy_run", 64'(busy), 64'(1));
         if (w_valid && first_v < 0) first_v = cyc;
         if (w_valid) chk("head", 64'({w_data, w_h, w_i, w_first, w_last}), 64'(exp_word(lay, k)));
         if (mode == 0) begin
            exp_a = lay * NW + ((cyc - 1 < NW - 1) ? cyc - 1 : NW - 1);
            chk("raddr", 64'(raddr), 64'(exp_a));
         end
         if (abort_at >= 0 && k == abort_at) begin
            abort = 1'b1;
            w_ready = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_state", 64'({w_valid, busy, done}), 64'(0));
            repeat (3) begin
               @(negedge clk);
               chk("abort_quiet", 64'({w_valid, busy, done}), 64'(0));
            end
            return;
         end
         if (reset_at >= 0 && cyc == reset_at) begin
            #2 rst_n = 1'b0;
            #1 chk("async_reset", 64'(all_outs()), 64'(0));
            @(negedge clk);
            #2 rst_n = 1'b1;
            repeat (3) begin
               @(negedge clk);
               chk("post_reset_idle", 64'(all_outs()), 64'(0));
            end
            return;
         end
         case (mode)
            0:       r = 1'b1;
            1:       r = ((cyc % 3) == 0);
            3:       r = !(cyc >= 4 && cyc < 9);
            default: r = 1'($urandom_range(0, 1));
         endcase
         w_ready = r;
         if (w_valid && !r) stalls++;
         start = poke && (cyc == 5);
         layer = (poke && cyc == 5) ? LW'((lay + 1) % N_LAYERS) : LW'(lay);
         if (w_valid && r) k++;
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      w_ready = 1'b0;
      chk("all_popped", 64'(k), 64'(NW));
      chk("no_early_done", 64'(saw_done), 64'(0));
      chk("done_pulse", 64'({done, busy}), 64'(2'b11));
      if (mode == 0) begin
         chk("first_latency", 64'(first_v), 64'(3));
         chk("done_time", 64'(cyc), 64'(first_v + NW));
      end
`ifdef WMEM_FETCH_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
      @(negedge clk);
      chk("after_done", 64'({done, busy, w_valid}), 64'(0));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_values", 64'(all_outs()), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 64'(all_outs()), 64'(0));

      run_layer(1, 0, 1'b0, -1, -1);
      run_layer(2, 1, 1'b0, -1, -1);

      layer = 2'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", 64'({err, busy, w_valid, raddr}), 64'({3'b100, 5'd23}));
      @(negedge clk);
      chk("err_clear", 64'({err, busy, w_valid, raddr}), 64'({3'b000, 5'd23}));

      run_layer(0, 0, 1'b0, 3, -1);
      run_layer(0, 0, 1'b0, -1, -1);
      run_layer(1, 2, 1'b0, -1, 6);
      run_layer(2, 2, 1'b1, -1, -1);
      run_layer(1, 3, 1'b0, -1, -1);
      for (int n = 0; n < 3; n++) run_layer(int'($urandom_range(0, N_LAYERS - 1)), 2, 1'b0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
